// File: rtl/obi_host_driver_mo.sv
// OBI host-side driver with up to MAX_OUTST in-flight transactions, a read/write tag FIFO and fence draining.
// Optional error reporting (err_i, resp_err_o, proto_err_o) is enabled by defining OBI_HOST_DRV_ERR_EN.
module obi_host_driver_mo #(
    parameter  int unsigned ADDR_W    = 64,
    parameter  int unsigned DATA_W    = 64,
    parameter  int unsigned MAX_OUTST = 2,
    localparam int unsigned BE_W      = DATA_W / 8,
    localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              fence_i,
    output logic              stall_ao,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              we_ao,
    output logic [BE_W-1:0]   be_ao,
    output logic [ADDR_W-1:0] addr_ao,
    output logic [DATA_W-1:0] wdata_ao,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              resp_we_o,
`ifdef OBI_HOST_DRV_ERR_EN
    input  logic              err_i,
    output logic              resp_err_o,
    output logic              proto_err_o,
`endif
    output logic [CNT_W-1:0]  outst_o
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTST-1:0] tag_q;

    logic                hold_we_q;
    logic [BE_W-1:0]     hold_be_q;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [DATA_W-1:0]   hold_wdata_q;

    logic                full_c, busy_c, push_c, pop_c;
    logic                issue_c, capture_c, req_c, we_c, stall_c;
    logic [BE_W-1:0]     be_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]   wdata_c;

    // A retire in the same cycle frees a slot, so rvalid_i feeds req_o combinationally.
    assign busy_c = (count_q != '0);
    assign full_c = (count_q == CNT_W'(MAX_OUTST)) && !rvalid_i;
    assign pop_c  = rvalid_i && busy_c;
    assign push_c = req_c && gnt_i;

    // Next-state and bus-side outputs
    always_comb begin
        state_d   = state_q;
        issue_c   = 1'b0;
        capture_c = 1'b0;
        req_c     = 1'b0;
        we_c      = wr_i;
        be_c      = be_i;
        addr_c    = addr_i;
        wdata_c   = wdata_i;
        stall_c   = ((rd_i || wr_i) && full_c) || (fence_i && busy_c);
        case (state_q)
            IDLE: begin
                issue_c = (rd_i || wr_i) && !stall_i && !fence_i && !full_c;
                req_c   = issue_c;
                if (issue_c && !gnt_i) begin
                    capture_c = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                req_c   = 1'b1;
                we_c    = hold_we_q;
                be_c    = hold_be_q;
                addr_c  = hold_addr_q;
                wdata_c = hold_wdata_q;
                stall_c = 1'b1;
                if (gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold registers keep an un-granted request stable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else if (capture_c) begin
            hold_we_q    <= wr_i;
            hold_be_q    <= be_i;
            hold_addr_q  <= addr_i;
            hold_wdata_q <= wdata_i;
        end
    end

    assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // In-flight counter and read/write tag FIFO share occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            count_q <= count_d;
            if (push_c) begin
                tag_q[wr_ptr_q] <= we_c;
                wr_ptr_q        <= (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Every output is forced low while reset is asserted
    assign req_o     = req_c && !rst_i;
    assign we_ao     = we_c && !rst_i;
    assign be_ao     = rst_i ? '0 : be_c;
    assign addr_ao   = rst_i ? '0 : addr_c;
    assign wdata_ao  = rst_i ? '0 : wdata_c;
    assign stall_ao  = stall_c && !rst_i;
    assign rvalid_o  = rvalid_i && !rst_i;
    assign rdata_o   = rst_i ? '0 : rdata_i;
    assign resp_we_o = busy_c && tag_q[rd_ptr_q] && !rst_i;
    assign outst_o   = rst_i ? '0 : count_q;

`ifdef OBI_HOST_DRV_ERR_EN
    logic proto_err_q;

    // Sticky protocol violation: response with nothing in flight, or read and write together
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_q <= 1'b0;
        end else if ((rvalid_i && !busy_c) || (rd_i && wr_i)) begin
            proto_err_q <= 1'b1;
        end
    end

    assign resp_err_o  = rvalid_i && err_i && !rst_i;
    assign proto_err_o = proto_err_q && !rst_i;
`endif

endmodule

// File: tb/tb_obi_host_driver_mo.sv
// Directed and randomized checks of obi_host_driver_mo against a queue-based transaction model.
module tb_obi_host_driver_mo;

    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned MAXO = 2;
    localparam int unsigned CW   = $clog2(MAXO + 1);

    logic          clk, rst_i;
    logic          rd_i, wr_i, stall_i, fence_i, gnt_i, rvalid_i;
    logic [BW-1:0] be_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i, rdata_i;
    logic          stall_ao, req_o, we_ao, rvalid_o, resp_we_o;
    logic [BW-1:0] be_ao;
    logic [AW-1:0] addr_ao;
    logic [DW-1:0] wdata_ao, rdata_o;
    logic [CW-1:0] outst_o;

    int errors = 0;
    int checks = 0;

    obi_host_driver_mo #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_i(stall_i), .fence_i(fence_i),
        .stall_ao(stall_ao), .req_o(req_o), .gnt_i(gnt_i), .we_ao(we_ao),
        .be_ao(be_ao), .addr_ao(addr_ao), .wdata_ao(wdata_ao), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .resp_we_o(resp_we_o), .outst_o(outst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: a queue of write flags for in-flight requests plus one pending request
    bit            m_tags[$];
    bit            m_hold;
    bit            m_hwe;
    logic [BW-1:0] m_hbe;
    logic [AW-1:0] m_haddr;
    logic [DW-1:0] m_hwd;
    bit            e_req, e_we, e_stall, e_issue;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    // Wait to mid-cycle and compare all outputs with the model's prediction
    task automatic settle();
        bit full;
        @(negedge clk);
        e_issue = 0;
        if (rst_i) begin
            e_req = 0; e_stall = 0;
        end else if (m_hold) begin
            e_req = 1; e_stall = 1;
            e_we = m_hwe; e_be = m_hbe; e_addr = m_haddr; e_wd = m_hwd;
        end else begin
            full    = (m_tags.size() == MAXO) && !rvalid_i;
            e_issue = (rd_i || wr_i) && !stall_i && !fence_i && !full;
            e_req   = e_issue;
            e_stall = ((rd_i || wr_i) && full) || (fence_i && m_tags.size() != 0);
            e_we = wr_i; e_be = be_i; e_addr = addr_i; e_wd = wdata_i;
        end
        chk1("req_o", req_o, e_req);
        chk1("stall_ao", stall_ao, e_stall);
        chk1("rvalid_o", rvalid_o, rvalid_i && !rst_i);
        chk("rdata_o", rdata_o, rst_i ? 64'd0 : rdata_i);
        chk1("resp_we_o", resp_we_o, (!rst_i && m_tags.size() > 0) ? m_tags[0] : 1'b0);
        chk("outst_o", 64'(outst_o), rst_i ? 64'd0 : 64'(m_tags.size()));
        if (e_req) begin
            chk1("we_ao", we_ao, e_we);
            chk("be_ao", 64'(be_ao), 64'(e_be));
            chk("addr_ao", addr_ao, e_addr);
            chk("wdata_ao", wdata_ao, e_wd);
        end
    endtask

    // Apply the clock edge to the model, then move to just after the DUT edge
    task automatic advance();
        if (rst_i) begin
            m_tags.delete();
            m_hold = 0;
        end else begin
            if (rvalid_i && m_tags.size() != 0) void'(m_tags.pop_front());
            if (e_req && gnt_i) m_tags.push_back(e_we);
            if (m_hold) begin
                if (gnt_i) m_hold = 0;
            end else if (e_issue && !gnt_i) begin
                m_hold = 1; m_hwe = wr_i; m_hbe = be_i; m_haddr = addr_i; m_hwd = wdata_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic host(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [7:0] be);
        rd_i = rd; wr_i = wr; addr_i = addr; wdata_i = wd; be_i = be;
    endtask

    task automatic bus(input logic gnt, input logic rv);
        gnt_i = gnt; rvalid_i = rv; rdata_i = {$urandom, $urandom};
    endtask

    initial begin
        rst_i = 1; stall_i = 0; fence_i = 0;
        host(0, 0, 0, 0, 0);
        bus(0, 0);
        m_hold = 0;

        // Reset state
        settle();
        chk1("rst_req", req_o, 1'b0);
        chk("rst_outst", 64'(outst_o), 64'd0);
        advance();
        cyc();
        rst_i = 0;

        // Single read with immediate grant and next-cycle response
        host(1, 0, 64'h1000, 0, 8'hFF); bus(1, 0);
        settle();
        chk1("rd_req", req_o, 1'b1);
        chk("rd_addr", addr_ao, 64'h1000);
        chk1("rd_stall", stall_ao, 1'b0);
        advance();
        host(0, 0, 0, 0, 0); bus(0, 1);
        settle();
        chk("rd_outst1", 64'(outst_o), 64'd1);
        chk1("rd_rvalid", rvalid_o, 1'b1);
        chk1("rd_resp_we", resp_we_o, 1'b0);
        chk1("rd_stall2", stall_ao, 1'b0);
        advance();
        bus(0, 0);
        settle();
        chk("rd_outst0", 64'(outst_o), 64'd0);
        advance();

        // Write held stable through three ungranted cycles while host inputs change
        host(0, 1, 64'h2000, 64'hDEAD_BEEF, 8'h0F); bus(0, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            host(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
            stall_i = 1'($urandom); fence_i = 1'($urandom);
            bus(i == 2, 0);
            settle();
            chk("hold_addr", addr_ao, 64'h2000);
            chk("hold_wdata", wdata_ao, 64'hDEAD_BEEF);
            chk("hold_be", 64'(be_ao), 64'h0F);
            chk1("hold_we", we_ao, 1'b1);
            chk1("hold_stall", stall_ao, 1'b1);
            advance();
        end
        host(0, 0, 0, 0, 0); stall_i = 0; fence_i = 0; bus(0, 1);
        settle();
        chk1("wr_resp_we", resp_we_o, 1'b1);
        advance();
        bus(0, 0); cyc();

        // Three back-to-back reads against a depth of two
        host(1, 0, 64'h3000, 0, 8'hFF); bus(1, 0);
        cyc(); cyc();
        settle();
        chk1("full_req", req_o, 1'b0);
        chk1("full_stall", stall_ao, 1'b1);
        advance();
        bus(1, 1);
        settle();
        chk1("retire_issue", req_o, 1'b1);
        chk1("retire_stall", stall_ao, 1'b0);
        advance();
        host(0, 0, 0, 0, 0); bus(0, 0);
        settle();
        chk("retire_outst", 64'(outst_o), 64'd2);
        advance();
        bus(0, 1); cyc(); cyc();
        bus(0, 0); cyc();

        // Write then read in flight: tags come back in order
        host(0, 1, 64'h4000, 64'h55, 8'h01); bus(1, 0); cyc();
        host(1, 0, 64'h4008, 0, 8'hFF); cyc();
        host(0, 0, 0, 0, 0); bus(0, 1);
        settle(); chk1("tag_wr", resp_we_o, 1'b1); advance();
        settle(); chk1("tag_rd", resp_we_o, 1'b0); advance();
        bus(0, 0); cyc();

        // Fence drains both in-flight reads
        host(1, 0, 64'h5000, 0, 8'hFF); bus(1, 0); cyc(); cyc();
        fence_i = 1; bus(1, 0);
        settle(); chk1("fence_stall", stall_ao, 1'b1); chk1("fence_req", req_o, 1'b0); advance();
        bus(1, 1);
        for (int i = 0; i < 2; i++) begin
            settle(); chk1("fence_drain", stall_ao, 1'b1); chk1("fence_noreq", req_o, 1'b0); advance();
        end
        bus(1, 0);
        settle();
        chk("fence_outst", 64'(outst_o), 64'd0);
        chk1("fence_done", stall_ao, 1'b0);
        chk1("fence_idle", req_o, 1'b0);
        advance();
        fence_i = 0; host(0, 0, 0, 0, 0); bus(0, 0); cyc();

        // Spurious response with nothing in flight
        bus(0, 1);
        settle(); chk1("spur_resp_we", resp_we_o, 1'b0); chk1("spur_rvalid", rvalid_o, 1'b1); advance();
        bus(0, 0); cyc();

        // Reset while holding with one transaction in flight
        host(1, 0, 64'h6000, 0, 8'hFF); bus(1, 0); cyc();
        bus(0, 0); cyc();
        rst_i = 1; cyc();
        rst_i = 0; host(0, 0, 0, 0, 0);
        settle();
        chk1("rst_hold_req", req_o, 1'b0);
        chk("rst_hold_outst", 64'(outst_o), 64'd0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned k;
            k = $urandom_range(0, 3);
            host(k == 1 || k == 3, k == 2, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
            stall_i = ($urandom_range(0, 9) == 0);
            fence_i = ($urandom_range(0, 9) == 0);
            bus($urandom_range(0, 9) < 6,
                (m_tags.size() > 0 && $urandom_range(0, 9) < 5) || $urandom_range(0, 49) == 0);
            rst_i = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
